// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Segment patterns are active-low with bit 7 = DP and bits 6:0 = g..a.
package seg7_pkg;

  localparam int         N_DIGITS = 4;
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] DIG_OFF  = 4'b1111;

  localparam logic [7:0] HEX_PAT [0:15] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic       blank;
    logic       dp;
    logic [3:0] val;
  } digit_t;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } state_e;

  localparam digit_t DIGIT_DARK = '{blank: 1'b1, dp: 1'b0, val: 4'h0};

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Producer-side write/commit bus and display pins of the scan controller.
// The producer (master) drives writes and commits; the controller (slave) drives status and pins.
interface seg7_scan_ctrl_if;
  logic       WR_EN;
  logic [1:0] WR_ADDR;
  logic [3:0] WR_DATA;
  logic       WR_DP;
  logic       WR_BLANK;
  logic       COMMIT;
  logic       PENDING;
  logic       FRAME;
  logic [3:0] DIG;
  logic [7:0] SEG;

  modport master (
    output WR_EN, WR_ADDR, WR_DATA, WR_DP, WR_BLANK, COMMIT,
    input  PENDING, FRAME, DIG, SEG
  );

  modport slave (
    input  WR_EN, WR_ADDR, WR_DATA, WR_DP, WR_BLANK, COMMIT,
    output PENDING, FRAME, DIG, SEG
  );
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational descriptor-to-segment decoder (active-low outputs).
// Blank overrides both value and decimal point.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  digit_t     i_digit,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = HEX_PAT[i_digit.val];
    if (i_digit.dp)    o_seg[7] = 1'b0;
    if (i_digit.blank) o_seg    = SEG_OFF;
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of four shadow/active digit descriptors onto shared DIG/SEG pins,
// with a dark gap before every digit and tear-free commits at frame boundaries.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGIT_CYC = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic             CLK,
  input  logic             RST,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int CYC_MAX = (DIGIT_CYC > BLANK_CYC) ? DIGIT_CYC : BLANK_CYC;
  localparam int CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYC - 1);

  digit_t           r_shadow [N_DIGITS];
  digit_t           r_active [N_DIGITS];
  state_e           r_state;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_dig;
  logic [7:0]       r_seg;
  logic             r_frame;
  logic             r_pending;

  logic       w_blank_done;
  logic       w_on_done;
  logic       w_boundary;
  state_e     w_state_next;
  logic [1:0] w_idx_next;
  logic [7:0] w_seg_dec;
  logic [3:0] w_dig_next;
  logic [7:0] w_seg_next;
  digit_t     w_wr_desc;

  assign w_blank_done = (r_state == S_BLANK) && (r_cnt == BLANK_LAST);
  assign w_on_done    = (r_state == S_ON)    && (r_cnt == DIGIT_LAST);
  assign w_boundary   = w_on_done && (r_idx == 2'd3);
  assign w_wr_desc    = '{blank: bus.WR_BLANK, dp: bus.WR_DP, val: bus.WR_DATA};

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    if (w_blank_done) begin
      w_state_next = S_ON;
    end else if (w_on_done) begin
      w_state_next = S_BLANK;
      w_idx_next   = r_idx + 2'd1;
    end
  end

  // Pins are loaded from the next state so they switch on the same edge as the FSM.
  seg7_hex_decode u_decode (
    .i_digit (r_active[w_idx_next]),
    .o_seg   (w_seg_dec)
  );

  assign w_dig_next = (w_state_next == S_ON) ? ~(4'b0001 << w_idx_next) : DIG_OFF;
  assign w_seg_next = (w_state_next == S_ON) ? w_seg_dec : SEG_OFF;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_BLANK;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_dig     <= DIG_OFF;
      r_seg     <= SEG_OFF;
      r_frame   <= 1'b0;
      r_pending <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        r_shadow[i] <= DIGIT_DARK;
        r_active[i] <= DIGIT_DARK;
      end
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= (w_blank_done || w_on_done) ? '0 : r_cnt + CNT_W'(1);
      r_dig   <= w_dig_next;
      r_seg   <= w_seg_next;
      r_frame <= w_boundary;
      // A commit on the boundary edge re-arms for the following frame.
      r_pending <= w_boundary ? bus.COMMIT : (r_pending | bus.COMMIT);
      if (w_boundary && r_pending) begin
        for (int i = 0; i < N_DIGITS; i++) r_active[i] <= r_shadow[i];
      end
      if (bus.WR_EN) r_shadow[bus.WR_ADDR] <= w_wr_desc;
    end
  end

  assign bus.DIG     = r_dig;
  assign bus.SEG     = r_seg;
  assign bus.FRAME   = r_frame;
  assign bus.PENDING = r_pending;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl with a frame-position reference model.
// Expected pins are derived from the cycle count since reset and the model's descriptor copies.
module tb_seg7_scan_ctrl;

  localparam int DC = 8;
  localparam int BC = 2;
  localparam int SL = DC + BC;
  localparam int FP = 4 * SL;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(.DIGIT_CYC(DC), .BLANK_CYC(BC)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       bl;
    logic       dp;
    logic [3:0] v;
  } mdesc_t;

  int     checks = 0;
  int     errors = 0;
  mdesc_t m_sh [4];
  mdesc_t m_ac [4];
  logic   m_pend;
  int     t;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [3:0] exp_dig();
    logic [3:0] one;
    int p;
    one = 4'b0001;
    p = t % FP;
    if ((p % SL) < BC) return 4'b1111;
    return ~(one << (p / SL));
  endfunction

  function automatic logic [7:0] exp_seg();
    int p, d;
    logic [7:0] s;
    p = t % FP;
    d = p / SL;
    if ((p % SL) < BC) return 8'hFF;
    if (m_ac[d].bl) return 8'hFF;
    s = hex7(m_ac[d].v);
    if (m_ac[d].dp) s[7] = 1'b0;
    return s;
  endfunction

  function automatic logic exp_frame();
    return (t > 0) && (t % FP == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_sh[i] = '{bl: 1'b1, dp: 1'b0, v: 4'h0};
      m_ac[i] = '{bl: 1'b1, dp: 1'b0, v: 4'h0};
    end
    m_pend = 1'b0;
    t = 0;
  endtask

  // Advance one clock, apply the frame rules to the model, clear one-cycle inputs.
  task automatic tick();
    @(posedge clk);
    if ((t + 1) % FP == 0) begin
      if (m_pend) m_ac = m_sh;
      m_pend = bus.COMMIT;
    end else begin
      m_pend = m_pend | bus.COMMIT;
    end
    if (bus.WR_EN) m_sh[bus.WR_ADDR] = '{bl: bus.WR_BLANK, dp: bus.WR_DP, v: bus.WR_DATA};
    t++;
    @(negedge clk);
    bus.WR_EN  = 1'b0;
    bus.COMMIT = 1'b0;
  endtask

  task automatic set_write(input logic [1:0] a, input logic [3:0] d, input logic dp, input logic bl);
    bus.WR_EN = 1'b1; bus.WR_ADDR = a; bus.WR_DATA = d; bus.WR_DP = dp; bus.WR_BLANK = bl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.DIG, bus.SEG, bus.PENDING, bus.FRAME} !== {4'b1111, 8'hFF, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold got DIG=%b SEG=%h P=%b F=%b exp 1111/FF/0/0", bus.DIG, bus.SEG, bus.PENDING, bus.FRAME);
      end
    end
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < FP + 5; n++) begin
      tick();
      checks++;
      if ({bus.DIG, bus.SEG} !== {exp_dig(), exp_seg()}) begin
        errors++;
        $display("FAIL reset_scan t=%0d got %b/%h exp %b/%h", t, bus.DIG, bus.SEG, exp_dig(), exp_seg());
      end
      checks++;
      if ({bus.PENDING, bus.FRAME} !== {m_pend, exp_frame()}) begin
        errors++;
        $display("FAIL reset_ctrl t=%0d got P=%b F=%b exp P=%b F=%b", t, bus.PENDING, bus.FRAME, m_pend, exp_frame());
      end
      if (t == BC + 1) begin
        checks++;
        if (bus.DIG !== 4'b1110) begin
          errors++;
          $display("FAIL first_lit t=%0d got DIG=%b exp 1110", t, bus.DIG);
        end
      end
    end
  endtask

  task automatic test_commit_basic();
    int tgt;
    for (int i = 0; i < 4; i++) begin
      set_write(2'(i), 4'(i + 1), 1'b0, 1'b0);
      tick();
    end
    bus.COMMIT = 1'b1;
    tick();
    checks++;
    if (bus.PENDING !== 1'b1) begin
      errors++;
      $display("FAIL commit_pending got %b exp 1", bus.PENDING);
    end
    tgt = (t / FP + 2) * FP;
    while (t < tgt) begin
      tick();
      checks++;
      if ({bus.DIG, bus.SEG, bus.PENDING, bus.FRAME} !== {exp_dig(), exp_seg(), m_pend, exp_frame()}) begin
        errors++;
        $display("FAIL commit_scan t=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", t, bus.DIG, bus.SEG,
                 bus.PENDING, bus.FRAME, exp_dig(), exp_seg(), m_pend, exp_frame());
      end
      if (t == tgt - FP + BC + 1) begin
        checks++;
        if ({bus.DIG, bus.SEG} !== {4'b1110, 8'hF9}) begin
          errors++;
          $display("FAIL commit_d0 got %b/%h exp 1110/F9", bus.DIG, bus.SEG);
        end
      end
      if (t == tgt - FP + 3 * SL + BC + 1) begin
        checks++;
        if ({bus.DIG, bus.SEG} !== {4'b0111, 8'h99}) begin
          errors++;
          $display("FAIL commit_d3 got %b/%h exp 0111/99", bus.DIG, bus.SEG);
        end
      end
    end
  endtask

  task automatic test_dp_blank();
    int tgt;
    set_write(2'd2, 4'hA, 1'b1, 1'b0);
    tick();
    set_write(2'd1, 4'h5, 1'b0, 1'b1);
    bus.COMMIT = 1'b1;
    tick();
    tgt = (t / FP + 2) * FP;
    while (t < tgt) begin
      tick();
      checks++;
      if ({bus.DIG, bus.SEG, bus.PENDING, bus.FRAME} !== {exp_dig(), exp_seg(), m_pend, exp_frame()}) begin
        errors++;
        $display("FAIL dpbl_scan t=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", t, bus.DIG, bus.SEG,
                 bus.PENDING, bus.FRAME, exp_dig(), exp_seg(), m_pend, exp_frame());
      end
      if (t == tgt - FP + 2 * SL + BC + 1) begin
        checks++;
        if ({bus.DIG, bus.SEG} !== {4'b1011, 8'h08}) begin
          errors++;
          $display("FAIL dp_digit got %b/%h exp 1011/08", bus.DIG, bus.SEG);
        end
      end
      if (t == tgt - FP + SL + BC + 1) begin
        checks++;
        if ({bus.DIG, bus.SEG} !== {4'b1101, 8'hFF}) begin
          errors++;
          $display("FAIL blank_digit got %b/%h exp 1101/FF", bus.DIG, bus.SEG);
        end
      end
    end
  endtask

  task automatic test_boundary_collision();
    int base;
    while ((t + 1) % FP != 0) tick();
    set_write(2'd0, 4'hF, 1'b0, 1'b0);
    bus.COMMIT = 1'b1;
    tick();
    base = t;
    checks++;
    if ({bus.PENDING, bus.FRAME} !== 2'b11) begin
      errors++;
      $display("FAIL collide_ctrl got P=%b F=%b exp P=1 F=1", bus.PENDING, bus.FRAME);
    end
    while (t < base + 2 * FP) begin
      tick();
      checks++;
      if ({bus.DIG, bus.SEG, bus.PENDING, bus.FRAME} !== {exp_dig(), exp_seg(), m_pend, exp_frame()}) begin
        errors++;
        $display("FAIL collide_scan t=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", t, bus.DIG, bus.SEG,
                 bus.PENDING, bus.FRAME, exp_dig(), exp_seg(), m_pend, exp_frame());
      end
      if (t == base + BC + 1) begin
        checks++;
        if (bus.SEG !== 8'hF9) begin
          errors++;
          $display("FAIL collide_old got SEG=%h exp F9", bus.SEG);
        end
      end
      if (t == base + FP + BC + 1) begin
        checks++;
        if (bus.SEG !== 8'h8E) begin
          errors++;
          $display("FAIL collide_new got SEG=%h exp 8E", bus.SEG);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    while (t % FP != BC + 3) tick();
    bus.COMMIT = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.DIG, bus.SEG, bus.PENDING, bus.FRAME} !== {4'b1111, 8'hFF, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got %b/%h/%b/%b exp 1111/FF/0/0", bus.DIG, bus.SEG, bus.PENDING, bus.FRAME);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < FP + 3; n++) begin
      tick();
      checks++;
      if ({bus.DIG, bus.SEG, bus.PENDING, bus.FRAME} !== {exp_dig(), exp_seg(), m_pend, exp_frame()}) begin
        errors++;
        $display("FAIL after_reset t=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", t, bus.DIG, bus.SEG,
                 bus.PENDING, bus.FRAME, exp_dig(), exp_seg(), m_pend, exp_frame());
      end
    end
  endtask

  task automatic test_multi_commit();
    int tgt;
    set_write(2'd3, 4'h7, 1'b0, 1'b0);
    tick();
    tgt = (t / FP + 2) * FP;
    while (t < tgt) begin
      if (t / FP == tgt / FP - 2 && (t % FP == 5 || t % FP == 15 || t % FP == 25)) bus.COMMIT = 1'b1;
      tick();
      checks++;
      if ({bus.DIG, bus.SEG, bus.PENDING, bus.FRAME} !== {exp_dig(), exp_seg(), m_pend, exp_frame()}) begin
        errors++;
        $display("FAIL multi_scan t=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", t, bus.DIG, bus.SEG,
                 bus.PENDING, bus.FRAME, exp_dig(), exp_seg(), m_pend, exp_frame());
      end
      if (t == tgt - FP) begin
        checks++;
        if (bus.PENDING !== 1'b0) begin
          errors++;
          $display("FAIL multi_clear got P=%b exp 0", bus.PENDING);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6 * FP; n++) begin
      if ($urandom_range(0, 2) == 0)
        set_write(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 15) == 0) bus.COMMIT = 1'b1;
      tick();
      checks++;
      if ({bus.DIG, bus.SEG, bus.PENDING, bus.FRAME} !== {exp_dig(), exp_seg(), m_pend, exp_frame()}) begin
        errors++;
        $display("FAIL random t=%0d got %b/%h/%b/%b exp %b/%h/%b/%b", t, bus.DIG, bus.SEG,
                 bus.PENDING, bus.FRAME, exp_dig(), exp_seg(), m_pend, exp_frame());
      end
    end
  endtask

  initial begin
    bus.WR_EN = 1'b0; bus.WR_ADDR = 2'd0; bus.WR_DATA = 4'h0;
    bus.WR_DP = 1'b0; bus.WR_BLANK = 1'b0; bus.COMMIT = 1'b0;
    model_reset();
    test_reset();
    test_commit_basic();
    test_dp_blank();
    test_boundary_collision();
    test_async_reset();
    test_multi_commit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
